flow_ctrl_fsm: RTL and testbench

Parametrised transaction-layer flow-control engine: tracks occupancy of the main FIFO, NUM_VC virtual-channel FIFOs and NUM_D destination FIFOs from their push/pop strobes. It compares each occupancy against a threshold captured at initialisation and drives per-FIFO pause (almost-full) lines. It also drives a RESET/INIT/IDLE/ACTIVE/ERROR state machine with idle/active/error status. It sits beside the FIFO datapath of the full-logic transmit block and replaces its fixed two-channel control.

---
 rtl/flow_ctrl_pkg.sv | 26 ++
 rtl/fifo_occ_tracker.sv | 70 +++++++
 rtl/flow_ctrl_fsm.sv | 177 +++++++++++++++++
 tb/tb_flow_ctrl_fsm.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_ctrl_pkg.sv
// Shared state codes and error_src bit-position helpers for the flow-control engine.
package flow_ctrl_pkg;

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StInit   = 3'd1,
        StIdle   = 3'd2,
        StActive = 3'd3,
        StError  = 3'd4
    } state_e;

    localparam int unsigned MF_IDX = 0;

    function automatic int unsigned vc_base();
        return 1;
    endfunction

    function automatic int unsigned d_base(input int unsigned num_vc);
        return 1 + num_vc;
    endfunction

    function automatic int unsigned num_ch(input int unsigned num_vc, input int unsigned num_d);
        return 1 + num_vc + num_d;
    endfunction

endpackage

// File: rtl/fifo_occ_tracker.sv
// Occupancy counter for one FIFO: overflow/underflow detection and registered almost-full pause.
module fifo_occ_tracker
    import flow_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned UMB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_force_pause,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [UMB_W-1:0] i_umbral,
    output logic             o_pause,
    output logic             o_nonzero_next,
    output logic             o_ovf,
    output logic             o_unf
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_pause;
    logic          w_full;
    logic          w_empty;
    logic          w_pause_next;

    always_comb begin
        w_full  = (r_cnt == FULL);
        w_empty = (r_cnt == '0);
        o_ovf   = i_en && i_push && !i_pop && w_full;
        // A pop on empty is an underflow even when a push arrives in the same cycle.
        o_unf   = i_en && i_pop && w_empty;

        w_cnt_next = r_cnt;
        if (i_clear) begin
            w_cnt_next = '0;
        end else if (i_en && !o_ovf && !o_unf) begin
            if (i_push && !i_pop) begin
                w_cnt_next = r_cnt + 1'b1;
            end else if (i_pop && !i_push) begin
                w_cnt_next = r_cnt - 1'b1;
            end
        end
        o_nonzero_next = (w_cnt_next != '0);

        if (32'(i_umbral) >= DEPTH) begin
            w_pause_next = 1'b1;
        end else begin
            w_pause_next = (32'(w_cnt_next) + 32'(i_umbral) >= DEPTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pause <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_next;
            r_pause <= i_force_pause | w_pause_next;
        end
    end

    assign o_pause = r_pause;

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Flow-control engine: per-FIFO occupancy trackers, threshold capture, status FSM and
// sticky error-source register.
module flow_ctrl_fsm
    import flow_ctrl_pkg::*;
#(
    parameter int unsigned NUM_VC   = 2,
    parameter int unsigned NUM_D    = 2,
    parameter int unsigned DEPTH_MF = 8,
    parameter int unsigned DEPTH_VC = 16,
    parameter int unsigned DEPTH_D  = 4,
    parameter int unsigned UMB_W    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [UMB_W-1:0]        umbral_MFs,
    input  logic [UMB_W-1:0]        umbral_VCs,
    input  logic [UMB_W-1:0]        umbral_Ds,
    input  logic                    mf_push,
    input  logic                    mf_pop,
    input  logic [NUM_VC-1:0]       vc_push,
    input  logic [NUM_VC-1:0]       vc_pop,
    input  logic [NUM_D-1:0]        d_push,
    input  logic [NUM_D-1:0]        d_pop,
    output logic                    pause_mf,
    output logic [NUM_VC-1:0]       pause_vc,
    output logic [NUM_D-1:0]        pause_d,
    output logic                    idle_out,
    output logic                    active_out,
    output logic                    error_out,
    output logic [2:0]              state_out,
    output logic [NUM_VC+NUM_D:0]   error_src
);

    localparam int unsigned NCH     = num_ch(NUM_VC, NUM_D);
    localparam int unsigned VC_BASE = vc_base();
    localparam int unsigned D_BASE  = d_base(NUM_VC);

    state_e           r_state;
    state_e           w_state_next;
    logic [UMB_W-1:0] r_umb_mf, r_umb_vc, r_umb_d;
    logic [UMB_W-1:0] w_umb_mf, w_umb_vc, w_umb_d;
    logic [NCH-1:0]   w_ovf, w_unf, w_nz, w_pause, w_err;
    logic [NCH-1:0]   r_err_src;
    logic             r_idle, r_active, r_error;
    logic             w_track, w_clear, w_capture, w_force_pause;

    assign w_track   = (r_state == StInit) || (r_state == StIdle) || (r_state == StActive);
    assign w_clear   = (r_state == StReset);
    assign w_capture = (r_state == StInit) && init;

    // Pause on the capture edge must already use the freshly latched thresholds.
    assign w_umb_mf = w_capture ? umbral_MFs : r_umb_mf;
    assign w_umb_vc = w_capture ? umbral_VCs : r_umb_vc;
    assign w_umb_d  = w_capture ? umbral_Ds  : r_umb_d;
    assign w_err    = w_ovf | w_unf;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StReset: w_state_next = StInit;
            StInit: begin
                if (|w_err) begin
                    w_state_next = StError;
                end else if (init) begin
                    w_state_next = (|w_nz) ? StActive : StIdle;
                end
            end
            StIdle, StActive: begin
                if (|w_err) begin
                    w_state_next = StError;
                end else begin
                    w_state_next = (|w_nz) ? StActive : StIdle;
                end
            end
            StError: w_state_next = StError;
            default: w_state_next = StReset;
        endcase
    end

    assign w_force_pause = (w_state_next == StReset) || (w_state_next == StInit) ||
                           (w_state_next == StError);

    fifo_occ_tracker #(
        .DEPTH (DEPTH_MF),
        .UMB_W (UMB_W)
    ) u_mf (
        .clk            (clk),
        .rst            (reset),
        .i_en           (w_track),
        .i_clear        (w_clear),
        .i_force_pause  (w_force_pause),
        .i_push         (mf_push),
        .i_pop          (mf_pop),
        .i_umbral       (w_umb_mf),
        .o_pause        (w_pause[MF_IDX]),
        .o_nonzero_next (w_nz[MF_IDX]),
        .o_ovf          (w_ovf[MF_IDX]),
        .o_unf          (w_unf[MF_IDX])
    );

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        fifo_occ_tracker #(
            .DEPTH (DEPTH_VC),
            .UMB_W (UMB_W)
        ) u_vc (
            .clk            (clk),
            .rst            (reset),
            .i_en           (w_track),
            .i_clear        (w_clear),
            .i_force_pause  (w_force_pause),
            .i_push         (vc_push[i]),
            .i_pop          (vc_pop[i]),
            .i_umbral       (w_umb_vc),
            .o_pause        (w_pause[VC_BASE+i]),
            .o_nonzero_next (w_nz[VC_BASE+i]),
            .o_ovf          (w_ovf[VC_BASE+i]),
            .o_unf          (w_unf[VC_BASE+i])
        );
    end

    for (genvar i = 0; i < NUM_D; i++) begin : g_d
        fifo_occ_tracker #(
            .DEPTH (DEPTH_D),
            .UMB_W (UMB_W)
        ) u_d (
            .clk            (clk),
            .rst            (reset),
            .i_en           (w_track),
            .i_clear        (w_clear),
            .i_force_pause  (w_force_pause),
            .i_push         (d_push[i]),
            .i_pop          (d_pop[i]),
            .i_umbral       (w_umb_d),
            .o_pause        (w_pause[D_BASE+i]),
            .o_nonzero_next (w_nz[D_BASE+i]),
            .o_ovf          (w_ovf[D_BASE+i]),
            .o_unf          (w_unf[D_BASE+i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StReset;
            r_umb_mf  <= '0;
            r_umb_vc  <= '0;
            r_umb_d   <= '0;
            r_idle    <= 1'b0;
            r_active  <= 1'b0;
            r_error   <= 1'b0;
            r_err_src <= '0;
        end else begin
            r_state  <= w_state_next;
            r_idle   <= (w_state_next == StIdle);
            r_active <= (w_state_next == StActive);
            r_error  <= (w_state_next == StError);
            if (w_capture) begin
                r_umb_mf <= umbral_MFs;
                r_umb_vc <= umbral_VCs;
                r_umb_d  <= umbral_Ds;
            end
            if (w_track) begin
                r_err_src <= r_err_src | w_err;
            end
        end
    end

    assign pause_mf   = w_pause[MF_IDX];
    assign pause_vc   = w_pause[VC_BASE +: NUM_VC];
    assign pause_d    = w_pause[D_BASE +: NUM_D];
    assign idle_out   = r_idle;
    assign active_out = r_active;
    assign error_out  = r_error;
    assign state_out  = r_state;
    assign error_src  = r_err_src;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Directed bench for flow_ctrl_fsm with a rule-level occupancy/state model checked every cycle.
module tb_flow_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset, init;
    logic [3:0] umb_mf, umb_vc, umb_d;
    logic       mf_push, mf_pop;
    logic [1:0] vc_push, vc_pop, d_push, d_pop;
    logic       pause_mf, idle_out, active_out, error_out;
    logic [1:0] pause_vc, pause_d;
    logic [2:0] state_out;
    logic [4:0] error_src;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: channel 0 = MF, 1..2 = VC0..1, 3..4 = D0..1; states 0..4 as numbered.
    int         m_state;
    int         m_cnt[5];
    int         m_thr[3];
    logic [4:0] m_src;

    flow_ctrl_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .umbral_MFs (umb_mf),
        .umbral_VCs (umb_vc),
        .umbral_Ds  (umb_d),
        .mf_push    (mf_push),
        .mf_pop     (mf_pop),
        .vc_push    (vc_push),
        .vc_pop     (vc_pop),
        .d_push     (d_push),
        .d_pop      (d_pop),
        .pause_mf   (pause_mf),
        .pause_vc   (pause_vc),
        .pause_d    (pause_d),
        .idle_out   (idle_out),
        .active_out (active_out),
        .error_out  (error_out),
        .state_out  (state_out),
        .error_src  (error_src)
    );

    always #5 clk = ~clk;

    function automatic int depth_of(input int ch);
        return (ch == 0) ? 8 : (ch < 3) ? 16 : 4;
    endfunction

    function automatic int grp_of(input int ch);
        return (ch == 0) ? 0 : (ch < 3) ? 1 : 2;
    endfunction

    function automatic logic exp_pause(input int ch);
        int dep;
        int umb;
        if (m_state == 0 || m_state == 1 || m_state == 4) return 1'b1;
        dep = depth_of(ch);
        umb = m_thr[grp_of(ch)];
        if (umb >= dep) return 1'b1;
        return (m_cnt[ch] >= dep - umb);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_src   = '0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        foreach (m_thr[i]) m_thr[i] = 0;
    endtask

    task automatic model_edge();
        logic [4:0] push, pop, e;
        int         nc[5];
        bit         any;
        if (reset) begin
            model_reset();
        end else begin
            push = {d_push, vc_push, mf_push};
            pop  = {d_pop, vc_pop, mf_pop};
            e    = '0;
            nc   = m_cnt;
            if (m_state >= 1 && m_state <= 3) begin
                for (int ch = 0; ch < 5; ch++) begin
                    if (pop[ch] && m_cnt[ch] == 0) e[ch] = 1'b1;
                    else if (push[ch] && !pop[ch] && m_cnt[ch] == depth_of(ch)) e[ch] = 1'b1;
                    else nc[ch] = m_cnt[ch] + int'(push[ch]) - int'(pop[ch]);
                end
                if (m_state == 1 && init) m_thr = '{int'(umb_mf), int'(umb_vc), int'(umb_d)};
                m_cnt = nc;
            end
            any = 1'b0;
            foreach (nc[i]) if (nc[i] != 0) any = 1'b1;
            if (m_state == 0) m_state = 1;
            else if (m_state == 4) m_state = 4;
            else if (e != 0) begin
                m_state = 4;
                m_src   = m_src | e;
            end else if (m_state == 1 && !init) m_state = 1;
            else m_state = any ? 3 : 2;
        end
    endtask

    task automatic check_all();
        check("state", 8'(state_out), 8'(m_state));
        check("idle", 8'(idle_out), 8'(m_state == 2));
        check("active", 8'(active_out), 8'(m_state == 3));
        check("error", 8'(error_out), 8'(m_state == 4));
        check("error_src", 8'(error_src), 8'(m_src));
        check("pause_mf", 8'(pause_mf), 8'(exp_pause(0)));
        check("pause_vc", 8'(pause_vc), 8'({exp_pause(2), exp_pause(1)}));
        check("pause_d", 8'(pause_d), 8'({exp_pause(4), exp_pause(3)}));
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic clear_strobes();
        mf_push = 0; mf_pop = 0; vc_push = 0; vc_pop = 0; d_push = 0; d_pop = 0;
    endtask

    // Asynchronous reset between edges, then release and initialise.
    task automatic reset_and_init();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        step(1);
        reset = 1'b0;
        step(2);
    endtask

    initial begin
        reset = 1'b0; init = 1'b1;
        umb_mf = 4'd5; umb_vc = 4'd4; umb_d = 4'd2;
        clear_strobes();
        model_reset();
        #2 reset = 1'b1;
        #1 check_all();

        // Reset held three cycles, then RESET -> INIT -> IDLE.
        step(3);
        check("rst_state_lit", 8'(state_out), 8'd0);
        check("rst_pause_lit", 8'({pause_mf, pause_vc, pause_d}), 8'b11111);
        reset = 1'b0;
        step(1);
        check("init_state_lit", 8'(state_out), 8'd1);
        step(1);
        check("idle_state_lit", 8'(state_out), 8'd2);
        check("idle_pause_lit", 8'({idle_out, pause_mf, pause_vc, pause_d}), 8'b100000);

        // Fill and drain VC0: threshold 16-4 = 12.
        vc_push = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (i == 1) check("vc0_active_lit", 8'(active_out), 8'd1);
            if (i == 11) check("vc0_11_lit", 8'(pause_vc), 8'b00);
        end
        check("vc0_12_lit", 8'(pause_vc), 8'b01);
        vc_push = 2'b00; vc_pop = 2'b01;
        step(12);
        vc_pop = 2'b00;
        check("vc0_drain_lit", 8'(idle_out), 8'd1);

        // D1: 2 pushes reach 4-2, then push+pop holds.
        d_push = 2'b10;
        step(2);
        check("d1_pause_lit", 8'(pause_d), 8'b10);
        d_pop = 2'b10;
        step(3);
        check("d1_hold_lit", 8'({error_out, pause_d}), 8'b010);
        d_push = 2'b00;
        step(2);
        d_pop = 2'b00;

        // init outside INIT must not recapture thresholds.
        umb_mf = 4'd0;
        step(1);

        // MF overflow.
        mf_push = 1'b1;
        step(8);
        check("mf_full_lit", 8'(pause_mf), 8'd1);
        step(1);
        mf_push = 1'b0;
        check("ovf_lit", 8'({error_out, state_out, error_src}), {1'b1, 3'd4, 5'b00001});
        vc_push = 2'b11; mf_pop = 1'b1; d_pop = 2'b11;
        step(3);
        clear_strobes();
        check("ovf_frozen_lit", 8'(error_src), 8'b00001);

        // Simultaneous underflow on D0 and VC1.
        umb_mf = 4'd5;
        reset_and_init();
        d_pop = 2'b01; vc_pop = 2'b10;
        step(1);
        clear_strobes();
        check("unf_lit", 8'(error_src), 8'b01100);
        check("unf_state_lit", 8'(state_out), 8'd4);

        // Reset mid-traffic with VC1 at 7, then re-init with 3/1/1.
        reset_and_init();
        vc_push = 2'b10;
        step(7);
        vc_push = 2'b00;
        check("vc1_active_lit", 8'(active_out), 8'd1);
        umb_mf = 4'd3; umb_vc = 4'd1; umb_d = 4'd1;
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("midrst_lit", 8'({state_out, pause_mf, pause_vc, pause_d}), 8'b00011111);
        step(1);
        reset = 1'b0;
        step(2);
        d_push = 2'b01;
        step(3);
        d_push = 2'b00;
        check("d0_thr1_lit", 8'(pause_d), 8'b01);
        mf_push = 1'b1;
        step(5);
        mf_push = 1'b0;
        check("mf_thr3_lit", 8'(pause_mf), 8'd1);

        // umbral 0 pauses only at full; umbral >= depth always pauses.
        umb_mf = 4'd0; umb_vc = 4'd15; umb_d = 4'd4;
        reset_and_init();
        check("d_umb4_lit", 8'(pause_d), 8'b11);
        mf_push = 1'b1;
        step(7);
        check("mf_umb0_7_lit", 8'(pause_mf), 8'd0);
        step(1);
        mf_push = 1'b0;
        check("mf_umb0_8_lit", 8'(pause_mf), 8'd1);
        vc_push = 2'b01;
        step(1);
        vc_push = 2'b00;
        check("vc_umb15_lit", 8'(pause_vc), 8'b01);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
